// File: rtl/uz_error_sequencer.sv
// uz_error_sequencer: latches masked error sources, trips the power stage and sequences it into a safe state
module uz_error_sequencer #(
  parameter int NUM_SRC        = 8,
  parameter int SHUTDOWN_DELAY = 100
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] err_in,
  input  logic [NUM_SRC-1:0] err_mask,
  input  logic               clear_req,
  input  logic               shutdown_ack,
  output logic               pwm_enable,
  output logic               safe_state,
  output logic [NUM_SRC-1:0] err_latched,
  output logic [3:0]         first_err_id,
  output logic [15:0]        err_count,
  output logic               ack_timeout,
  output logic [1:0]         state
);
  typedef enum logic [1:0] {RUN = 2'b00, TRIP = 2'b01, WAIT_ACK = 2'b10, SAFE = 2'b11} state_t;
  localparam int TW = SHUTDOWN_DELAY > 1 ? $clog2(SHUTDOWN_DELAY) : 1;
  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] eff, eff_q, latched_q;
  logic [TW-1:0]      timer_q;
  logic [3:0]         low_id, first_q;
  logic [15:0]        count_q;
  logic               pwm_q, safe_q, ack_to_q, clear_ok, timeout, rise;
  always_comb begin
    eff = err_in & ~err_mask;
    rise = |(eff & ~eff_q);
    low_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (eff[i]) low_id = 4'(i);
    clear_ok = state_q == SAFE && clear_req && eff == '0;
    timeout = state_q == WAIT_ACK && !shutdown_ack && timer_q == '0;
    state_d = state_q == RUN      ? (|eff ? TRIP : RUN) :
              state_q == TRIP     ? WAIT_ACK :
              state_q == WAIT_ACK ? ((shutdown_ack || timer_q == '0) ? SAFE : WAIT_ACK) :
                                    (clear_ok ? RUN : SAFE);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= SAFE;
      pwm_q     <= 1'b0;
      safe_q    <= 1'b1;
      eff_q     <= '0;
      latched_q <= '0;
      first_q   <= '0;
      count_q   <= '0;
      ack_to_q  <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      pwm_q     <= state_d == RUN;
      safe_q    <= state_d == SAFE;
      eff_q     <= eff;
      latched_q <= clear_ok ? '0 : latched_q | eff;
      count_q   <= (rise && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
      first_q   <= (state_q == RUN && |eff) ? low_id : clear_ok ? 4'd0 : first_q;
      ack_to_q  <= timeout ? 1'b1 : clear_ok ? 1'b0 : ack_to_q;
      timer_q   <= state_q == TRIP ? TW'(SHUTDOWN_DELAY - 1) :
                   (state_q == WAIT_ACK && timer_q != '0) ? timer_q - 1'b1 : timer_q;
    end
  end
  assign pwm_enable   = pwm_q;
  assign safe_state   = safe_q;
  assign err_latched  = latched_q;
  assign first_err_id = first_q;
  assign err_count    = count_q;
  assign ack_timeout  = ack_to_q;
  assign state        = state_q;
endmodule
